// File: rtl/game_flow_pkg.sv
// -----------------------------------------------------------------------------
// game_flow_pkg
// Shared definitions for the game flow controller:
//   - game_state_t   : MENU / PLAY / OVER state encoding
//   - SEL_BACKGROUND : obstacle mux select value meaning "background only"
//   - LFSR_SEED/TAPS : reset value and feedback taps of the optional 8-bit
//                      LFSR (x^8 + x^6 + x^5 + x^4 + 1)
// No ports (package).
// -----------------------------------------------------------------------------
package game_flow_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [3:0] SEL_BACKGROUND = 4'd0;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Bits 7,5,4,3 of a left-shifting Fibonacci register realise
    // x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl_if
// Bundles the game flow controller's player/video inputs and its status
// outputs.
//   master : the environment (drives vsync_in, game_start, menu_req, hit_in)
//   slave  : the controller (drives obstacle_mux_select, game_on, hp,
//            invulnerable, game_over, state_dbg)
// Signalling: there is no valid/ready handshake on this bundle. Every input
// is level-sampled on each rising pclk edge, and every output is a register
// that is valid on every cycle; the consumer never stalls the controller.
// state_dbg mirrors the FSM state register for observation.
// -----------------------------------------------------------------------------
interface game_flow_ctrl_if;
    import game_flow_pkg::*;

    logic        vsync_in;
    logic        game_start;
    logic        menu_req;
    logic        hit_in;
    logic [3:0]  obstacle_mux_select;
    logic        game_on;
    logic [3:0]  hp;
    logic        invulnerable;
    logic        game_over;
    game_state_t state_dbg;

    modport master (
        output vsync_in, game_start, menu_req, hit_in,
        input  obstacle_mux_select, game_on, hp, invulnerable, game_over,
               state_dbg
    );

    modport slave (
        input  vsync_in, game_start, menu_req, hit_in,
        output obstacle_mux_select, game_on, hp, invulnerable, game_over,
               state_dbg
    );

endinterface

// File: rtl/game_flow_lfsr.sv
// -----------------------------------------------------------------------------
// game_flow_lfsr
// Free-running 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1), seeded with
// LFSR_SEED at reset and stepping every cycle. Only built when
// GAME_FLOW_RANDOM_EN is defined.
// Ports:
//   pclk      in   clock
//   rst_n     in   asynchronous active-low reset
//   lfsr_lo_o out  low nibble of the register (candidate obstacle index)
// -----------------------------------------------------------------------------
`ifdef GAME_FLOW_RANDOM_EN
module game_flow_lfsr
    import game_flow_pkg::*;
(
    input  logic       pclk,
    input  logic       rst_n,
    output logic [3:0] lfsr_lo_o
);

    logic [7:0] lfsr_q;
    logic       feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], feedback};
        end
    end

    assign lfsr_lo_o = lfsr_q[3:0];

endmodule
`endif

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Game flow state machine (MENU / PLAY / OVER) paced by VGA frames. In PLAY
// it walks through obstacle channels every STAGE_FRAMES frames, counts hit
// points down on hits and runs an invulnerability window after each hit.
// Optional feature macro: GAME_FLOW_RANDOM_EN -- when defined, a stage
// advance picks the next obstacle from a free-running LFSR instead of
// stepping sequentially.
// Ports:
//   pclk   in  pixel clock, all logic on its rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    game_flow_ctrl_if.slave: vsync_in, game_start, menu_req, hit_in in;
//          obstacle_mux_select, game_on, hp, invulnerable, game_over,
//          state_dbg out (all registered)
// -----------------------------------------------------------------------------
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int N_OBSTACLES   = 4,
    parameter int STAGE_FRAMES  = 600,
    parameter int INVULN_FRAMES = 60,
    parameter int HP_MAX        = 3
) (
    input  logic             pclk,
    input  logic             rst_n,
    game_flow_ctrl_if.slave  bus
);

    localparam int TW = (STAGE_FRAMES > 1) ? $clog2(STAGE_FRAMES) : 1;
    localparam int IW = $clog2(INVULN_FRAMES + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(STAGE_FRAMES - 1);
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);
    localparam logic [3:0]    IDX_LAST   = 4'(N_OBSTACLES - 1);
    localparam logic [3:0]    HP_INIT    = 4'(HP_MAX);

    // Frame tick: vsync rising edge, registered. armed_q blocks an edge
    // until vsync has been seen low once after reset, so a vsync that is
    // already high when reset releases does not count as a frame.
    logic vsync_q, armed_q, tick_q;

    game_state_t   state_q, state_d;
    logic [3:0]    hp_q, hp_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] inv_q, inv_d;

    logic [3:0] sel_q;
    logic       game_on_q, inv_flag_q, over_q;

    logic [3:0] seq_idx, adv_idx;

    assign seq_idx = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;

`ifdef GAME_FLOW_RANDOM_EN
    logic [3:0] lfsr_lo;

    game_flow_lfsr u_lfsr (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .lfsr_lo_o (lfsr_lo)
    );

    // Out-of-range LFSR values fall back to the sequential step.
    assign adv_idx = (lfsr_lo < 4'(N_OBSTACLES)) ? lfsr_lo : seq_idx;
`else
    assign adv_idx = seq_idx;
`endif

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        inv_d   = inv_q;
        if (bus.menu_req) begin
            state_d = MENU;
            inv_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (tick_q) begin
                        if (timer_q == TIMER_LAST) begin
                            timer_d = '0;
                            idx_d   = adv_idx;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                        if (inv_q != '0) begin
                            inv_d = inv_q - 1'b1;
                        end
                    end
                    // Eligibility uses the counter value before this
                    // cycle's frame decrement.
                    if (bus.hit_in && (inv_q == '0)) begin
                        if (hp_q <= 4'd1) begin
                            hp_d    = 4'd0;
                            state_d = OVER;
                            inv_d   = '0;
                        end else begin
                            hp_d  = hp_q - 4'd1;
                            inv_d = INV_LOAD;
                        end
                    end
                end
                default: begin
                    if (bus.game_start) begin
                        state_d = PLAY;
                        hp_d    = HP_INIT;
                        idx_d   = 4'd0;
                        timer_d = '0;
                        inv_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            armed_q    <= 1'b0;
            tick_q     <= 1'b0;
            state_q    <= MENU;
            hp_q       <= HP_INIT;
            idx_q      <= 4'd0;
            timer_q    <= '0;
            inv_q      <= '0;
            sel_q      <= SEL_BACKGROUND;
            game_on_q  <= 1'b0;
            inv_flag_q <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            vsync_q    <= bus.vsync_in;
            armed_q    <= armed_q | ~bus.vsync_in;
            tick_q     <= bus.vsync_in & ~vsync_q & armed_q;
            state_q    <= state_d;
            hp_q       <= hp_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            inv_q      <= inv_d;
            // Outputs are computed from next-state so they line up with
            // the state registers on the same cycle.
            sel_q      <= (state_d == PLAY) ? idx_d + 4'd1 : SEL_BACKGROUND;
            game_on_q  <= (state_d == PLAY);
            inv_flag_q <= (inv_d != '0);
            over_q     <= (state_d == OVER);
        end
    end

    assign bus.obstacle_mux_select = sel_q;
    assign bus.game_on             = game_on_q;
    assign bus.hp                  = hp_q;
    assign bus.invulnerable        = inv_flag_q;
    assign bus.game_over           = over_q;
    assign bus.state_dbg           = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Self-checking bench for game_flow_ctrl (N_OBSTACLES=3, STAGE_FRAMES=4,
// INVULN_FRAMES=2, HP_MAX=3): a directed vector table, hand-written reset
// sequences, and random stimulus against a frame-counting reference model.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;
    import game_flow_pkg::*;

    localparam int N   = 3;
    localparam int SF  = 4;
    localparam int IV  = 2;
    localparam int HPM = 3;

`ifdef GAME_FLOW_RANDOM_EN
    localparam logic [10:0] CMP_MASK = 11'h07F;
`else
    localparam logic [10:0] CMP_MASK = 11'h7FF;
`endif

    localparam int OP_IDLE  = 0;
    localparam int OP_FRAME = 1;

    // ---------------- clock / reset ----------------
    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    always #5 pclk = ~pclk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .N_OBSTACLES   (N),
        .STAGE_FRAMES  (SF),
        .INVULN_FRAMES (IV),
        .HP_MAX        (HPM)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] dut_outs();
        return {bus.obstacle_mux_select, bus.game_on, bus.hp,
                bus.invulnerable, bus.game_over};
    endfunction

    // ---------------- reference model ----------------
    // Game progress is tracked as frames played since start; the obstacle
    // is (frames / STAGE_FRAMES) mod N.
    int m_state;     // 0 menu, 1 play, 2 over
    int m_hp;
    int m_frames;
    int m_inv;
    bit m_tick, m_vs_prev, m_armed;

    task automatic model_reset();
        m_state = 0; m_hp = HPM; m_frames = 0; m_inv = 0;
        m_tick = 0; m_vs_prev = 0; m_armed = 0;
    endtask

    task automatic model_step(input bit vs, input bit gs, input bit mr,
                              input bit ht);
        bit frame_now;
        bit hit_ok;
        frame_now = m_tick;
        if (mr) begin
            m_state = 0;
            m_inv   = 0;
        end else if (m_state != 1) begin
            if (gs) begin
                m_state = 1; m_hp = HPM; m_frames = 0; m_inv = 0;
            end
        end else begin
            hit_ok = ht && (m_inv == 0);
            if (frame_now) begin
                m_frames++;
                if (m_inv > 0) m_inv--;
            end
            if (hit_ok) begin
                m_hp--;
                m_inv = IV;
                if (m_hp == 0) begin
                    m_state = 2;
                    m_inv   = 0;
                end
            end
        end
        m_tick    = vs && !m_vs_prev && m_armed;
        m_armed   = m_armed || !vs;
        m_vs_prev = vs;
    endtask

    function automatic logic [10:0] model_outs();
        logic [3:0] sel;
        sel = (m_state == 1) ? 4'(((m_frames / SF) % N) + 1) : 4'd0;
        return {sel, (m_state == 1), 4'(m_hp), (m_inv != 0), (m_state == 2)};
    endfunction

    task automatic compare_model(input string name);
        logic [10:0] e;
        exp_q.push_back(model_outs());
        e = exp_q.pop_front();
        check(name, 32'(dut_outs() & CMP_MASK), 32'(e & CMP_MASK));
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cycle(input bit vs, input bit gs, input bit mr,
                               input bit ht);
        bus.vsync_in   = vs;
        bus.game_start = gs;
        bus.menu_req   = mr;
        bus.hit_in     = ht;
        @(posedge pclk);
        model_step(vs, gs, mr, ht);
        #1;
    endtask

    task automatic drive_frame(input bit gs, input bit mr, input bit ht);
        drive_cycle(1'b1, gs, mr, ht);
        drive_cycle(1'b0, gs, mr, ht);
        drive_cycle(1'b0, gs, mr, ht);
    endtask

    task automatic do_reset(input bit vs);
        bus.vsync_in   = vs;
        bus.game_start = 1'b0;
        bus.menu_req   = 1'b0;
        bus.hit_in     = 1'b0;
        rst_n = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         op;
        bit         gs, mr, ht;
        logic [3:0] sel;
        logic       on;
        logic [3:0] hp;
        logic       inv;
        logic       over;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int op, input bit gs, input bit mr, input bit ht,
                       input int sel, input bit on, input int hp,
                       input bit inv, input bit over);
        vec_t v;
        v.op = op; v.gs = gs; v.mr = mr; v.ht = ht;
        v.sel = 4'(sel); v.on = on; v.hp = 4'(hp); v.inv = inv; v.over = over;
        tbl.push_back(v);
    endtask

    initial begin
        int sel_seq[12];
        bit vs;
        int vs_cnt;

        sel_seq = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};

        // start, 12 frames of stage walking
        add(OP_IDLE, 1, 0, 0, 1, 1, 3, 0, 0);
        add(OP_IDLE, 0, 0, 0, 1, 1, 3, 0, 0);
        for (int i = 0; i < 12; i++) add(OP_FRAME, 0, 0, 0, sel_seq[i], 1, 3, 0, 0);
        // hit held across frames
        add(OP_IDLE,  0, 0, 1, 1, 1, 2, 1, 0);
        add(OP_FRAME, 0, 0, 1, 1, 1, 2, 1, 0);
        add(OP_FRAME, 0, 0, 1, 1, 1, 1, 1, 0);
        add(OP_FRAME, 0, 0, 0, 1, 1, 1, 1, 0);
        add(OP_FRAME, 0, 0, 0, 2, 1, 1, 0, 0);
        // last hit, extra hit, restart
        add(OP_IDLE,  0, 0, 1, 0, 0, 0, 0, 1);
        add(OP_IDLE,  0, 0, 1, 0, 0, 0, 0, 1);
        add(OP_FRAME, 0, 0, 1, 0, 0, 0, 0, 1);
        add(OP_IDLE,  1, 0, 0, 1, 1, 3, 0, 0);
        // three spaced hits
        add(OP_IDLE,  0, 0, 1, 1, 1, 2, 1, 0);
        add(OP_FRAME, 0, 0, 0, 1, 1, 2, 1, 0);
        add(OP_FRAME, 0, 0, 0, 1, 1, 2, 0, 0);
        add(OP_IDLE,  0, 0, 1, 1, 1, 1, 1, 0);
        add(OP_FRAME, 0, 0, 0, 1, 1, 1, 1, 0);
        add(OP_FRAME, 0, 0, 0, 2, 1, 1, 0, 0);
        add(OP_IDLE,  0, 0, 1, 0, 0, 0, 0, 1);
        add(OP_IDLE,  0, 0, 1, 0, 0, 0, 0, 1);
        // menu wins over start in OVER, then start again
        add(OP_IDLE,  1, 1, 0, 0, 0, 0, 0, 0);
        add(OP_IDLE,  1, 0, 0, 1, 1, 3, 0, 0);

        do_reset(1'b0);
        check("reset_outs", 32'(dut_outs()), 32'({4'd0, 1'b0, 4'd3, 1'b0, 1'b0}));
        check("reset_state", 32'(bus.state_dbg), 32'(MENU));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].op == OP_IDLE) drive_cycle(1'b0, tbl[i].gs, tbl[i].mr, tbl[i].ht);
            else                      drive_frame(tbl[i].gs, tbl[i].mr, tbl[i].ht);
            check($sformatf("vec%0d", i), 32'(dut_outs() & CMP_MASK),
                  32'({tbl[i].sel, tbl[i].on, tbl[i].hp, tbl[i].inv, tbl[i].over} & CMP_MASK));
        end

        // async reset mid-PLAY, checked before any clock edge
        drive_frame(0, 0, 1);
        @(posedge pclk);
        #3;
        bus.vsync_in = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(dut_outs()), 32'({4'd0, 1'b0, 4'd3, 1'b0, 1'b0}));
        check("async_rst_state", 32'(bus.state_dbg), 32'(MENU));

        // vsync already high at reset release must not count as a frame
        do_reset(1'b1);
        drive_cycle(1'b1, 1, 0, 0);
        drive_cycle(1'b1, 0, 0, 0);
        drive_cycle(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_frame(0, 0, 0);
        check("vs_high_rel_3fr", 32'(bus.obstacle_mux_select & CMP_MASK[10:7]), 32'(4'd1 & CMP_MASK[10:7]));
        drive_frame(0, 0, 0);
        check("vs_high_rel_4fr", 32'(bus.obstacle_mux_select & CMP_MASK[10:7]), 32'(4'd2 & CMP_MASK[10:7]));

        // random stimulus against the model
        do_reset(1'b0);
        vs = 1'b0;
        vs_cnt = 2;
        for (int c = 0; c < 3000; c++) begin
            if (vs_cnt == 0) begin
                vs = ~vs;
                vs_cnt = $urandom_range(1, 4);
            end else begin
                vs_cnt--;
            end
            drive_cycle(vs, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0),
                        ($urandom_range(0, 5) == 0));
            compare_model($sformatf("rand_c%0d", c));
        end

`ifdef GAME_FLOW_RANDOM_EN
        begin
            int  prev_sel;
            bit  nonseq;
            do_reset(1'b0);
            drive_cycle(1'b0, 1, 0, 0);
            prev_sel = int'(bus.obstacle_mux_select);
            nonseq = 1'b0;
            for (int a = 0; a < 50; a++) begin
                for (int f = 0; f < SF; f++) drive_frame(0, 0, 0);
                check($sformatf("lfsr_range%0d", a),
                      32'((bus.obstacle_mux_select >= 4'd1) && (bus.obstacle_mux_select <= 4'd3)), 32'd1);
                if (int'(bus.obstacle_mux_select) != (prev_sel % N) + 1) nonseq = 1'b1;
                prev_sel = int'(bus.obstacle_mux_select);
            end
            check("lfsr_nonseq", 32'(nonseq), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have parameter N_OBSTACLES, default 4, number of obstacle channels (1..15).
REQ-002 The block SHALL have parameter STAGE_FRAMES, default 600, frames per obstacle stage (>=1).
REQ-003 The block SHALL have parameter INVULN_FRAMES, default 60, frames of invulnerability after a hit (>=1).
REQ-004 The block SHALL have parameter HP_MAX, default 3, starting hit points (1..15).
REQ-005 pclk  input  1  pixel clock; the block's one clock, all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 vsync_in  input  1  VGA vertical sync; rising edge marks one frame.
REQ-008 game_start  input  1  play request, level-sampled.
REQ-009 menu_req  input  1  return-to-menu request, level-sampled.
REQ-010 hit_in  input  1  collision or damage strobe, level-sampled.
REQ-011 obstacle_mux_select  output  4  mux select: 0 = background only, k = obstacle channel k.
REQ-012 game_on  output  1  high in PLAY; drives the mouse-constraint mode.
REQ-013 hp  output  4  remaining hit points.
REQ-014 invulnerable  output  1  high while the invulnerability window runs.
REQ-015 game_over  output  1  high in OVER.
REQ-016 All outputs SHALL be registered.

Function
REQ-017 frame_tick SHALL be high for one cycle, one cycle after each 0->1 edge of vsync_in.
REQ-018 The state machine SHALL have three states: MENU, PLAY and OVER.
REQ-019 menu_req high SHALL force MENU from any state and takes priority over every other input.
REQ-020 game_start high in MENU or OVER SHALL give PLAY on the next cycle, with hp=HP_MAX, obstacle index 0, stage timer 0 and invulnerability counter 0.
REQ-021 In PLAY, the stage timer SHALL increment on each frame_tick.
REQ-022 When the stage timer reaches STAGE_FRAMES-1 on a frame_tick, the timer SHALL clear and the obstacle index SHALL advance.
- Advance is index+1, wrapping N_OBSTACLES-1 -> 0.
REQ-023 obstacle_mux_select SHALL equal index+1 in PLAY and 0 in MENU and OVER.
REQ-024 In PLAY, hit_in high with the invulnerability counter at 0 SHALL, on the next cycle:
- decrement hp by 1;
- load the invulnerability counter with INVULN_FRAMES.
REQ-025 hit_in SHALL be ignored while the invulnerability counter is non-zero, and outside PLAY.
REQ-026 The invulnerability counter SHALL decrement on each frame_tick while non-zero.
- invulnerable = (counter != 0).
REQ-027 A hit with hp==1 SHALL, in the same cycle, set hp to 0, enter OVER and set game_over=1.
- Stage timer and index freeze in OVER.
REQ-028 hp SHALL never underflow below 0.
REQ-029 A hit and a stage advance in the same cycle SHALL both take effect.
REQ-030 Leaving PLAY SHALL clear the invulnerability counter.

Reset
REQ-031 Asserting rst_n low SHALL, immediately and at any time (mid-game included), give:
- state MENU, obstacle_mux_select=0, game_on=0;
- hp=HP_MAX, invulnerable=0, game_over=0;
- timers and index 0, vsync edge register 0.
REQ-032 After rst_n deasserts, the first vsync_in edge SHALL be detected only after a low sample.

Configuration
REQ-033 With GAME_FLOW_RANDOM_EN defined, a stage advance SHALL set the index from a free-running 8-bit LFSR.
- LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset, steps every cycle.
- Next index = lfsr[3:0] if lfsr[3:0] < N_OBSTACLES, else sequential index+1 with wrap.
REQ-034 With GAME_FLOW_RANDOM_EN undefined, advance SHALL be purely sequential and no LFSR SHALL be built.

Structure
REQ-035 Package game_flow_pkg SHALL hold:
- the state encoding (MENU/PLAY/OVER);
- select constant SEL_BACKGROUND=0;
- LFSR seed and taps.
REQ-036 The LFSR SHALL be a sub-module, game_flow_lfsr, instantiated only under GAME_FLOW_RANDOM_EN.

Verification
Bench parameters for all scenarios: N_OBSTACLES=3, STAGE_FRAMES=4, INVULN_FRAMES=2, HP_MAX=3; macro undefined unless stated.
REQ-037 Reset, then game_start pulse -> next cycle game_on=1, obstacle_mux_select=1, hp=3.
REQ-038 12 vsync edges in PLAY -> select sequence 1,2,3,1: changes every 4 frames and wraps.
REQ-039 hit_in held 3 frames -> hp 3->2 once, invulnerable=1 for 2 frames, then hp->1 on the next eligible cycle.
REQ-040 Three spaced hits -> hp=0, game_over=1, select=0; a further hit leaves hp=0; game_start restarts with hp=3.
REQ-041 menu_req and game_start both high in OVER -> MENU; rst_n low mid-PLAY -> all outputs at reset values without a clock edge.
REQ-042 With GAME_FLOW_RANDOM_EN: 50 stage advances -> select always in 1..3, and the sequence is not purely sequential.
